clause_vs_ls_store: RTL and testbench

- Register-file store for one bin of the SAT engine: a clause array, a per-variable state list (vs) and a per-level state list (ls).
- Loaded and unloaded by the bin manager through one-hot write/read enables.
- Also computes combinational per-clause status (satisfied / conflict / unit) from the stored clauses and variable values; the core state machine consumes this for BCP and partial-SAT detection.

---
 rtl/clause_vs_ls_store.sv | 135 +++++++++++++
 tb/tb_clause_vs_ls_store.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_vs_ls_store.sv
// Register-file store for one SAT-engine bin: clause array, per-variable
// state list (vs) and per-level state list (ls), plus combinational
// per-clause satisfied / conflict / unit status for BCP.
// Optional feature macro: CLAUSE_FREE_CNT_EN adds c_free_cnt_o, a saturating
// count of free literals per clause.
module clause_vs_ls_store #(
  parameter int unsigned NUM_CLAUSES      = 8,
  parameter int unsigned NUM_VARS         = 8,
  parameter int unsigned NUM_LVLS         = 8,
  parameter int unsigned WIDTH_BIN_ID     = 10,
`ifdef CLAUSE_FREE_CNT_EN
  parameter int unsigned WIDTH_C_LEN      = 4,
`endif
  parameter int unsigned WIDTH_LVL        = 16,
  parameter int unsigned WIDTH_VAR_STATES = 2 + 1 + WIDTH_LVL,
  parameter int unsigned WIDTH_LVL_STATES = WIDTH_BIN_ID + 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CLAUSES-1:0]                 wr_carray_i,
  input  logic [2*NUM_VARS-1:0]                  clause_i,
  input  logic [NUM_CLAUSES-1:0]                 rd_carray_i,
  output logic [2*NUM_VARS-1:0]                  clause_o,
  input  logic [NUM_VARS-1:0]                    wr_var_states,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_i,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
  input  logic [NUM_LVLS-1:0]                    wr_lvl_states,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_i,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
  output logic [NUM_CLAUSES-1:0]                 c_sat_o,
  output logic [NUM_CLAUSES-1:0]                 c_conflict_o,
  output logic [NUM_CLAUSES-1:0]                 c_unit_o,
`ifdef CLAUSE_FREE_CNT_EN
  output logic [WIDTH_C_LEN*NUM_CLAUSES-1:0]     c_free_cnt_o,
`endif
  output logic                                   all_c_sat_o
);

  localparam int unsigned CLAUSE_W = 2 * NUM_VARS;
  localparam int unsigned CNT_W    = $clog2(NUM_VARS + 1);
`ifdef CLAUSE_FREE_CNT_EN
  localparam int unsigned C_LEN_MAX = (1 << WIDTH_C_LEN) - 1;
`endif

  logic [CLAUSE_W-1:0]                  clause_q [NUM_CLAUSES];
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_q;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvls_q;

  // Storage writes: each enabled row/slot captures its data; reset clears all
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLAUSES; i++) clause_q[i] <= '0;
      vars_q <= '0;
      lvls_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CLAUSES; i++) begin
        if (wr_carray_i[i]) clause_q[i] <= clause_i;
      end
      for (int j = 0; j < NUM_VARS; j++) begin
        if (wr_var_states[j])
          vars_q[j*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] <=
            vars_states_i[j*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
      end
      for (int k = 0; k < NUM_LVLS; k++) begin
        if (wr_lvl_states[k])
          lvls_q[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] <=
            lvl_states_i[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
      end
    end
  end

  assign vars_states_o = vars_q;
  assign lvl_states_o  = lvls_q;

  // Clause readback: OR of every selected row
  always_comb begin
    clause_o = '0;
    for (int i = 0; i < NUM_CLAUSES; i++) begin
      if (rd_carray_i[i]) clause_o = clause_o | clause_q[i];
    end
  end

  for (genvar gi = 0; gi < NUM_CLAUSES; gi++) begin : g_clause
    logic             any_present;
    logic             any_sat;
    logic             all_false;
    logic [CNT_W-1:0] n_free;
    logic [1:0]       lit;
    logic [1:0]       val;
    logic             present;
    logic             val_free;

    // Classify each literal of this clause against the current var values
    always_comb begin
      any_present = 1'b0;
      any_sat     = 1'b0;
      all_false   = 1'b1;
      n_free      = '0;
      lit         = '0;
      val         = '0;
      present     = 1'b0;
      val_free    = 1'b0;
      for (int j = 0; j < NUM_VARS; j++) begin
        lit      = clause_q[gi][2*j +: 2];
        val      = vars_q[j*WIDTH_VAR_STATES +: 2];
        // codes 1/2 are real literals/values; 0 and 3 mean absent/free
        present  = (lit == 2'd1) || (lit == 2'd2);
        val_free = (val == 2'd0) || (val == 2'd3);
        if (present) begin
          any_present = 1'b1;
          if (val_free) begin
            n_free    = n_free + CNT_W'(1);
            all_false = 1'b0;
          end else if (val == lit) begin
            any_sat   = 1'b1;
            all_false = 1'b0;
          end
        end
      end
    end

    // Non-free, non-sat present literals are false, so one free + unsat = unit
    assign c_sat_o[gi]      = any_sat | ~any_present;
    assign c_conflict_o[gi] = any_present & all_false;
    assign c_unit_o[gi]     = ~any_sat & (n_free == CNT_W'(1));

`ifdef CLAUSE_FREE_CNT_EN
    assign c_free_cnt_o[gi*WIDTH_C_LEN +: WIDTH_C_LEN] =
      (32'(n_free) > C_LEN_MAX) ? WIDTH_C_LEN'(C_LEN_MAX) : WIDTH_C_LEN'(n_free);
`endif
  end

  assign all_c_sat_o = &c_sat_o;

endmodule

// File: tb/tb_clause_vs_ls_store.sv
// Directed self-checking bench for clause_vs_ls_store.
module tb_clause_vs_ls_store;

  localparam int unsigned NC  = 8;
  localparam int unsigned NV  = 8;
  localparam int unsigned NL  = 8;
  localparam int unsigned WVS = 19;
  localparam int unsigned WLS = 11;

  logic                clk;
  logic                rst;
  logic [NC-1:0]       wr_carray_i;
  logic [2*NV-1:0]     clause_i;
  logic [NC-1:0]       rd_carray_i;
  logic [2*NV-1:0]     clause_o;
  logic [NV-1:0]       wr_var_states;
  logic [WVS*NV-1:0]   vars_states_i;
  logic [WVS*NV-1:0]   vars_states_o;
  logic [NL-1:0]       wr_lvl_states;
  logic [WLS*NL-1:0]   lvl_states_i;
  logic [WLS*NL-1:0]   lvl_states_o;
  logic [NC-1:0]       c_sat_o;
  logic [NC-1:0]       c_conflict_o;
  logic [NC-1:0]       c_unit_o;
  logic                all_c_sat_o;
`ifdef CLAUSE_FREE_CNT_EN
  logic [4*NC-1:0]     c_free_cnt_o;
`endif

  int checks;
  int failures;

  logic [WVS*NV-1:0] vs_exp;
  logic [WLS*NL-1:0] ls_exp;

  clause_vs_ls_store dut (
    .clk           (clk),
    .rst           (rst),
    .wr_carray_i   (wr_carray_i),
    .clause_i      (clause_i),
    .rd_carray_i   (rd_carray_i),
    .clause_o      (clause_o),
    .wr_var_states (wr_var_states),
    .vars_states_i (vars_states_i),
    .vars_states_o (vars_states_o),
    .wr_lvl_states (wr_lvl_states),
    .lvl_states_i  (lvl_states_i),
    .lvl_states_o  (lvl_states_o),
    .c_sat_o       (c_sat_o),
    .c_conflict_o  (c_conflict_o),
    .c_unit_o      (c_unit_o),
`ifdef CLAUSE_FREE_CNT_EN
    .c_free_cnt_o  (c_free_cnt_o),
`endif
    .all_c_sat_o   (all_c_sat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic write_clause(input logic [NC-1:0] en, input logic [2*NV-1:0] data);
    wr_carray_i = en;
    clause_i    = data;
    @(posedge clk); #1;
    wr_carray_i = '0;
    clause_i    = '0;
  endtask

  task automatic write_vars(input logic [NV-1:0] en, input logic [WVS*NV-1:0] data);
    wr_var_states = en;
    vars_states_i = data;
    @(posedge clk); #1;
    wr_var_states = '0;
    vars_states_i = '0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rd_carray_i = 8'hFF;
    #1;
    checks++; if (clause_o !== 16'h0) begin failures++; $display("FAIL reset_clause got %h exp %h", clause_o, 16'h0); end
    checks++; if (vars_states_o !== '0) begin failures++; $display("FAIL reset_vars got %h exp 0", vars_states_o); end
    checks++; if (lvl_states_o !== '0) begin failures++; $display("FAIL reset_lvls got %h exp 0", lvl_states_o); end
    checks++; if (c_sat_o !== 8'hFF || all_c_sat_o !== 1'b1) begin failures++; $display("FAIL reset_sat got %h/%b exp ff/1", c_sat_o, all_c_sat_o); end
    checks++; if (c_conflict_o !== 8'h00 || c_unit_o !== 8'h00) begin failures++; $display("FAIL reset_conf_unit got %h/%h exp 00/00", c_conflict_o, c_unit_o); end
    rd_carray_i = '0;
  endtask

  task automatic test_clause_load;
    logic [2*NV-1:0] exp_rows [3];
    exp_rows[0] = 16'h0012;
    exp_rows[1] = 16'h0048;
    exp_rows[2] = 16'h0220;
    for (int i = 0; i < 3; i++) write_clause(NC'(1 << i), exp_rows[i]);
    for (int i = 0; i < 3; i++) begin
      rd_carray_i = NC'(1 << i);
      #1;
      checks++; if (clause_o !== exp_rows[i]) begin failures++; $display("FAIL read_row%0d got %h exp %h", i, clause_o, exp_rows[i]); end
    end
    rd_carray_i = 8'h03; #1;
    checks++; if (clause_o !== 16'h005A) begin failures++; $display("FAIL read_or got %h exp %h", clause_o, 16'h005A); end
    rd_carray_i = 8'h00; #1;
    checks++; if (clause_o !== 16'h0000) begin failures++; $display("FAIL read_none got %h exp %h", clause_o, 16'h0000); end
    checks++; if (c_sat_o !== 8'hF8 || c_conflict_o !== 8'h00 || c_unit_o !== 8'h00) begin
      failures++; $display("FAIL load_status got %h/%h/%h exp f8/00/00", c_sat_o, c_conflict_o, c_unit_o); end
    checks++; if (all_c_sat_o !== 1'b0) begin failures++; $display("FAIL load_all_sat got %b exp 0", all_c_sat_o); end
`ifdef CLAUSE_FREE_CNT_EN
    checks++; if (c_free_cnt_o !== 32'h0000_0222) begin failures++; $display("FAIL free_cnt got %h exp %h", c_free_cnt_o, 32'h0000_0222); end
`endif
  endtask

  task automatic test_unit;
    vs_exp = '0;
    vs_exp[0*WVS +: WVS] = 19'h00011;
    write_vars(8'hFF, vs_exp);
    checks++; if (vars_states_o[18:0] !== 19'h00011) begin failures++; $display("FAIL unit_var0 got %h exp %h", vars_states_o[18:0], 19'h00011); end
    checks++; if (vars_states_o !== vs_exp) begin failures++; $display("FAIL unit_vars got %h exp %h", vars_states_o, vs_exp); end
    checks++; if (c_unit_o !== 8'h01 || c_sat_o !== 8'hF8 || c_conflict_o !== 8'h00) begin
      failures++; $display("FAIL unit_status got %h/%h/%h exp 01/f8/00", c_unit_o, c_sat_o, c_conflict_o); end
  endtask

  task automatic test_sat_all;
    vs_exp = '0;
    vs_exp[0*WVS +: WVS] = 19'h00011;
    vs_exp[1*WVS +: WVS] = 19'h1;
    vs_exp[2*WVS +: WVS] = 19'h1;
    vs_exp[3*WVS +: WVS] = 19'h1;
    vs_exp[4*WVS +: WVS] = 19'h2;
    write_vars(8'hFF, vs_exp);
    checks++; if (c_sat_o !== 8'hFF || all_c_sat_o !== 1'b1) begin failures++; $display("FAIL sat_all got %h/%b exp ff/1", c_sat_o, all_c_sat_o); end
    checks++; if (c_unit_o !== 8'h00 || c_conflict_o !== 8'h00) begin failures++; $display("FAIL sat_all_cu got %h/%h exp 00/00", c_unit_o, c_conflict_o); end
  endtask

  task automatic test_conflict;
    logic [WVS*NV-1:0] data;
    data = {(WVS*NV){1'b1}};
    data[2*WVS +: WVS] = 19'h1;
    data[4*WVS +: WVS] = 19'h1;
    write_vars(8'b0001_0100, data);
    vs_exp[4*WVS +: WVS] = 19'h1;
    checks++; if (vars_states_o !== vs_exp) begin failures++; $display("FAIL conf_vars got %h exp %h", vars_states_o, vs_exp); end
    checks++; if (c_conflict_o !== 8'h04 || all_c_sat_o !== 1'b0) begin failures++; $display("FAIL conflict got %h/%b exp 04/0", c_conflict_o, all_c_sat_o); end
    checks++; if (c_sat_o !== 8'hFB || c_unit_o !== 8'h00) begin failures++; $display("FAIL conf_su got %h/%h exp fb/00", c_sat_o, c_unit_o); end
  endtask

  task automatic test_value3_free;
    logic [WVS*NV-1:0] data;
    data = '0;
    data[2*WVS +: WVS] = 19'h3;
    write_vars(8'b0000_0100, data);
    checks++; if (c_unit_o !== 8'h05 || c_conflict_o !== 8'h00 || c_sat_o !== 8'hFA) begin
      failures++; $display("FAIL val3_status got %h/%h/%h exp 05/00/fa", c_unit_o, c_conflict_o, c_sat_o); end
  endtask

  task automatic test_absent_and_multi;
    write_clause(8'h20, 16'hFFFF);
    write_clause(8'h40, 16'h0400);
    checks++; if (c_sat_o !== 8'hBA || c_unit_o !== 8'h45) begin failures++; $display("FAIL absent_code got %h/%h exp ba/45", c_sat_o, c_unit_o); end
    write_clause(8'hC0, 16'h0400);
    checks++; if (c_sat_o !== 8'h3A || c_unit_o !== 8'hC5) begin failures++; $display("FAIL multi_wr got %h/%h exp 3a/c5", c_sat_o, c_unit_o); end
    rd_carray_i = 8'h80; #1;
    checks++; if (clause_o !== 16'h0400) begin failures++; $display("FAIL multi_rd7 got %h exp %h", clause_o, 16'h0400); end
    rd_carray_i = 8'h20; #1;
    checks++; if (clause_o !== 16'hFFFF) begin failures++; $display("FAIL rd5 got %h exp %h", clause_o, 16'hFFFF); end
    rd_carray_i = '0;
  endtask

  task automatic test_lvl;
    logic [WLS*NL-1:0] data;
    data = '0;
    data[0*WLS +: WLS] = 11'h123;
    wr_lvl_states = 8'h01; lvl_states_i = data;
    @(posedge clk); #1;
    data = {(WLS*NL){1'b1}};
    data[3*WLS +: WLS] = 11'h405;
    wr_lvl_states = 8'h08; lvl_states_i = data;
    wr_carray_i = 8'h80; clause_i = 16'h0000;
    @(posedge clk); #1;
    wr_lvl_states = '0; lvl_states_i = '0; wr_carray_i = '0;
    ls_exp = '0;
    ls_exp[0*WLS +: WLS] = 11'h123;
    ls_exp[3*WLS +: WLS] = 11'h405;
    checks++; if (lvl_states_o[3*WLS +: WLS] !== 11'h405) begin failures++; $display("FAIL lvl_slot3 got %h exp %h", lvl_states_o[3*WLS +: WLS], 11'h405); end
    checks++; if (lvl_states_o !== ls_exp) begin failures++; $display("FAIL lvl_all got %h exp %h", lvl_states_o, ls_exp); end
    checks++; if (c_sat_o !== 8'hBA || c_unit_o !== 8'h45) begin failures++; $display("FAIL same_cycle_clause got %h/%h exp ba/45", c_sat_o, c_unit_o); end
  endtask

  task automatic test_reset_mid;
    wr_carray_i   = 8'h01;
    clause_i      = 16'h0001;
    wr_var_states = 8'hFF;
    vars_states_i = {(WVS*NV){1'b1}};
    wr_lvl_states = 8'hFF;
    lvl_states_i  = {(WLS*NL){1'b1}};
    @(negedge clk);
    rst = 1'b1;
    #1;
    rd_carray_i = 8'hFF; #1;
    checks++; if (clause_o !== 16'h0 || vars_states_o !== '0 || lvl_states_o !== '0) begin
      failures++; $display("FAIL async_rst_store got %h/%h/%h exp 0", clause_o, vars_states_o, lvl_states_o); end
    checks++; if (c_sat_o !== 8'hFF || all_c_sat_o !== 1'b1 || c_conflict_o !== 8'h00 || c_unit_o !== 8'h00) begin
      failures++; $display("FAIL async_rst_status got %h/%b/%h/%h exp ff/1/00/00", c_sat_o, all_c_sat_o, c_conflict_o, c_unit_o); end
    @(posedge clk); #1;
    wr_carray_i = '0; wr_var_states = '0; wr_lvl_states = '0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (clause_o !== 16'h0 || vars_states_o !== '0 || lvl_states_o !== '0) begin
      failures++; $display("FAIL rst_hold_store got %h/%h/%h exp 0", clause_o, vars_states_o, lvl_states_o); end
    rd_carray_i = '0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    wr_carray_i   = '0;
    clause_i      = '0;
    rd_carray_i   = '0;
    wr_var_states = '0;
    vars_states_i = '0;
    wr_lvl_states = '0;
    lvl_states_i  = '0;
    vs_exp        = '0;
    ls_exp        = '0;
    test_reset();
    test_clause_load();
    test_unit();
    test_sat_all();
    test_conflict();
    test_value3_free();
    test_absent_and_multi();
    test_lvl();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
